// File: rtl/pl_descrambler_if.sv
// Symbol stream bundle for the DVB-S2 PL descrambler: input side, output side and handshakes.
interface pl_descrambler_if #(
  parameter int W = 16
) ();
  logic signed [W-1:0] in_i;
  logic signed [W-1:0] in_q;
  logic                in_valid;
  logic                in_sof;
  logic                in_ready;
  logic signed [W-1:0] out_i;
  logic signed [W-1:0] out_q;
  logic                out_valid;
  logic                out_sof;
  logic                out_hdr;
  logic                out_ready;

  modport master (
    output in_i, in_q, in_valid, in_sof, out_ready,
    input  in_ready, out_i, out_q, out_valid, out_sof, out_hdr
  );

  modport slave (
    input  in_i, in_q, in_valid, in_sof, out_ready,
    output in_ready, out_i, out_q, out_valid, out_sof, out_hdr
  );
endinterface

// File: rtl/pl_descrambler.sv
// DVB-S2 receive-side PL descrambler: header symbols pass through, payload symbols are
// de-rotated by the conjugate Gold-code sequence (code index 0), one output register stage.
module pl_descrambler #(
  parameter int W       = 16,
  parameter int HDR_LEN = 90
) (
  input logic             clk,
  input logic             reset,
  pl_descrambler_if.slave bus
);
  localparam int               CNT_W    = 7;
  localparam logic [17:0]      X_INIT   = 18'h00001;
  localparam logic [17:0]      Y_INIT   = 18'h3FFFF;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    hdr_cnt;
  logic [17:0]         x;
  logic [17:0]         y;
  logic [1:0]          code;
  logic                accept;
  logic signed [W-1:0] neg_i;
  logic signed [W-1:0] neg_q;
  logic signed [W-1:0] rot_i;
  logic signed [W-1:0] rot_q;
  logic signed [W-1:0] out_i_r;
  logic signed [W-1:0] out_q_r;
  logic                out_valid_r;
  logic                out_sof_r;
  logic                out_hdr_r;

  // Negating the most negative value would overflow; clamp to the most positive one.
  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] a);
    if (a == {1'b1, {(W-1){1'b0}}})
      return {1'b0, {(W-1){1'b1}}};
    return -a;
  endfunction

  assign code = {x[4] ^ x[6] ^ x[15] ^ y[5] ^ y[6] ^ y[8] ^ y[9] ^ y[10] ^ y[11] ^
                 y[12] ^ y[13] ^ y[14] ^ y[15],
                 x[0] ^ y[0]};

  assign bus.in_ready  = !out_valid_r || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_i     = out_i_r;
  assign bus.out_q     = out_q_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sof   = out_sof_r;
  assign bus.out_hdr   = out_hdr_r;

  always_comb begin
    neg_i = neg_sat(bus.in_i);
    neg_q = neg_sat(bus.in_q);
    rot_i = bus.in_i;
    rot_q = bus.in_q;
    case (code)
      2'd1: begin rot_i = bus.in_q; rot_q = neg_i;    end
      2'd2: begin rot_i = neg_i;    rot_q = neg_q;    end
      2'd3: begin rot_i = neg_q;    rot_q = bus.in_i; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hdr_cnt     <= '0;
      x           <= X_INIT;
      y           <= Y_INIT;
      out_i_r     <= '0;
      out_q_r     <= '0;
      out_valid_r <= 1'b0;
      out_sof_r   <= 1'b0;
      out_hdr_r   <= 1'b0;
    end else begin
      if (bus.out_ready)
        out_valid_r <= 1'b0;
      if (accept) begin
        if (bus.in_sof) begin
          // A start-of-frame always restarts the frame, whatever the current state.
          out_i_r     <= bus.in_i;
          out_q_r     <= bus.in_q;
          out_valid_r <= 1'b1;
          out_sof_r   <= 1'b1;
          out_hdr_r   <= 1'b1;
          hdr_cnt     <= CNT_W'(1);
          x           <= X_INIT;
          y           <= Y_INIT;
          if (HDR_LEN == 1)
            state <= PAYLOAD;
          else
            state <= HDR;
        end else begin
          case (state)
            HDR: begin
              out_i_r     <= bus.in_i;
              out_q_r     <= bus.in_q;
              out_valid_r <= 1'b1;
              out_sof_r   <= 1'b0;
              out_hdr_r   <= 1'b1;
              hdr_cnt     <= hdr_cnt + CNT_W'(1);
              if (hdr_cnt == HDR_LAST) begin
                state <= PAYLOAD;
                x     <= X_INIT;
                y     <= Y_INIT;
              end
            end
            PAYLOAD: begin
              out_i_r     <= rot_i;
              out_q_r     <= rot_q;
              out_valid_r <= 1'b1;
              out_sof_r   <= 1'b0;
              out_hdr_r   <= 1'b0;
              x           <= {x[0] ^ x[7], x[17:1]};
              y           <= {y[0] ^ y[5] ^ y[7] ^ y[10], y[17:1]};
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_pl_descrambler.sv
// Scoreboard bench for pl_descrambler: driver pushes expected symbols, monitor pops and compares.
module tb_pl_descrambler;
  localparam int W       = 16;
  localparam int HDR_LEN = 90;

  typedef struct {
    int i;
    int q;
    bit sof;
    bit hdr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  bit   bp_en = 1'b0;
  exp_t sb[$];

  int          m_state = 0;
  int          m_cnt = 0;
  logic [17:0] mx = 18'h00001;
  logic [17:0] my = 18'h3FFFF;
  int          k2 = -1;

  pl_descrambler_if #(.W(W)) bus ();

  pl_descrambler #(.W(W), .HDR_LEN(HDR_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] gold(input logic [17:0] gx, input logic [17:0] gy);
    return {gx[4] ^ gx[6] ^ gx[15] ^ gy[5] ^ gy[6] ^ gy[8] ^ gy[9] ^ gy[10] ^ gy[11] ^
            gy[12] ^ gy[13] ^ gy[14] ^ gy[15], gx[0] ^ gy[0]};
  endfunction

  function automatic int nsat(input int v);
    int n;
    n = -v;
    if (n > 32767) n = 32767;
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input int i, input int q, input bit sof, input bit ovr,
                       input int ei, input int eq);
    exp_t e;
    bit   push;
    logic [1:0] r;
    push = 1'b0;
    e.i = i; e.q = q; e.sof = 1'b0; e.hdr = 1'b1;
    if (sof) begin
      e.sof = 1'b1; push = 1'b1; m_cnt = 1;
      m_state = (HDR_LEN == 1) ? 2 : 1;
      mx = 18'h00001; my = 18'h3FFFF;
    end else if (m_state == 1) begin
      push = 1'b1;
      m_cnt++;
      if (m_cnt == HDR_LEN) begin
        m_state = 2; mx = 18'h00001; my = 18'h3FFFF;
      end
    end else if (m_state == 2) begin
      push = 1'b1; e.hdr = 1'b0;
      r = gold(mx, my);
      case (r)
        2'd1: begin e.i = q;       e.q = nsat(i); end
        2'd2: begin e.i = nsat(i); e.q = nsat(q); end
        2'd3: begin e.i = nsat(q); e.q = i;       end
        default: ;
      endcase
      mx = {mx[0] ^ mx[7], mx[17:1]};
      my = {my[0] ^ my[5] ^ my[7] ^ my[10], my[17:1]};
    end
    if (push) begin
      if (ovr) begin e.i = ei; e.q = eq; end
      sb.push_back(e);
    end
  endtask

  task automatic send(input int i, input int q, input bit sof, input bit ovr = 1'b0,
                      input int ei = 0, input int eq = 0);
    bit done;
    model(i, q, sof, ovr, ei, eq);
    bus.in_i = W'(i);
    bus.in_q = W'(q);
    bus.in_sof = sof;
    bus.in_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 1000 cycles");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "input handshake stalled");
    end
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
  endtask

  task automatic send_header();
    send(0, 0, 1'b1);
    for (int k = 1; k < HDR_LEN; k++) send(k, -k, 1'b0);
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    bit   held;
    int   hv_i, hv_q;
    bit   hv_sof, hv_hdr;
    exp_t e;
    held = 1'b0;
    hv_i = 0; hv_q = 0; hv_sof = 1'b0; hv_hdr = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else if (!bus.out_valid) begin
        if (held) begin
          compared++; mismatched++;
          $display("FAIL stall_drop: out_valid 0 while stalled, required 1");
          held = 1'b0;
        end
      end else begin
        if (held) begin
          compared++;
          if (int'(bus.out_i) != hv_i || int'(bus.out_q) != hv_q ||
              bus.out_sof != hv_sof || bus.out_hdr != hv_hdr) begin
            mismatched++;
            $display("FAIL stall_hold: got (%0d,%0d) held (%0d,%0d)",
                     bus.out_i, bus.out_q, hv_i, hv_q);
          end
        end
        if (bus.out_ready) begin
          held = 1'b0;
          compared++;
          if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_out: got (%0d,%0d) sof=%0b hdr=%0b, required no output",
                     bus.out_i, bus.out_q, bus.out_sof, bus.out_hdr);
          end else begin
            e = sb.pop_front();
            if (int'(bus.out_i) != e.i || int'(bus.out_q) != e.q ||
                bus.out_sof != e.sof || bus.out_hdr != e.hdr)
            begin
              mismatched++;
              $display("FAIL data: got (%0d,%0d) sof=%0b hdr=%0b expected (%0d,%0d) sof=%0b hdr=%0b",
                       bus.out_i, bus.out_q, bus.out_sof, bus.out_hdr, e.i, e.q, e.sof, e.hdr);
            end
          end
        end else begin
          held = 1'b1;
          hv_i = int'(bus.out_i); hv_q = int'(bus.out_q);
          hv_sof = bus.out_sof; hv_hdr = bus.out_hdr;
        end
      end
    end
  end

  initial begin : stimulus
    logic [17:0] sx, sy;
    int n;
    idle_in();
    bus.in_i = '0;
    bus.in_q = '0;

    // Locate the first payload position carrying R=2 for the saturation vector.
    sx = 18'h00001; sy = 18'h3FFFF;
    for (int k = 0; k < 1000 && k2 < 0; k++) begin
      if (gold(sx, sy) == 2'd2) k2 = k;
      sx = {sx[0] ^ sx[7], sx[17:1]};
      sy = {sy[0] ^ sy[5] ^ sy[7] ^ sy[10], sy[17:1]};
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_sof", int'(bus.out_sof), 0);
    check("rst_out_hdr", int'(bus.out_hdr), 0);
    check("rst_out_i", int'(bus.out_i), 0);
    check("rst_out_q", int'(bus.out_q), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Header pass-through then sequence start with hand values for R0 and R1.
    send_header();
    send(100, 20, 1'b0, 1'b1, 100, 20);
    send(100, 20, 1'b0, 1'b1, 20, -100);
    send(100, 20, 1'b0);
    send(100, 20, 1'b0);
    for (int k = 0; k < 2000; k++) send(rnd(), rnd(), 1'b0);

    // Back-pressure run.
    bp_en = 1'b1;
    send_header();
    for (int k = 0; k < 300; k++) send(rnd(), rnd(), 1'b0);
    idle_in();
    repeat (20) @(posedge clk);
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Restart at payload symbol 37.
    send_header();
    for (int k = 0; k < 37; k++) send(rnd(), rnd(), 1'b0);
    send(-7, 9, 1'b1);
    for (int k = 1; k < HDR_LEN; k++) send(k, k, 1'b0);
    send(5, 7, 1'b0, 1'b1, 5, 7);
    send(5, 7, 1'b0, 1'b1, 7, -5);

    // Saturation at an R=1 and an R=2 position.
    send_header();
    send(1, 1, 1'b0, 1'b1, 1, 1);
    send(-32768, -32768, 1'b0, 1'b1, -32768, 32767);
    for (int k = 2; k < k2; k++) send(rnd(), rnd(), 1'b0);
    send(-32768, -32768, 1'b0, 1'b1, 32767, 32767);
    check("r2_found", int'(k2 > 1), 1);

    // Reset mid-payload, then discarded symbols in IDLE, then a fresh frame.
    for (int k = 0; k < 10; k++) send(rnd(), rnd(), 1'b0);
    idle_in();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    reset = 1'b0;
    sb.delete();
    m_state = 0;
    m_cnt = 0;
    for (int k = 0; k < 5; k++) send(11 + k, 22 + k, 1'b0);
    idle_in();
    @(negedge clk);
    check("idle_no_out", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    send_header();
    send(300, -400, 1'b0, 1'b1, 300, -400);
    send(300, -400, 1'b0, 1'b1, -400, -300);
    idle_in();

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check("drain_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
